// File: rtl/output_conditioner_pkg.sv
// Shared definitions for the input/output conditioners: FSM state encodings
// and the default dwell counter width and dwell length.
package output_conditioner_pkg;

  typedef enum logic [0:0] {
    STATE_IDLE  = 1'b0,
    STATE_DWELL = 1'b1
  } state_t;

  localparam int DEFAULT_COUNTERWIDTH = 3;
  localparam int DEFAULT_WAITTIME     = 3;

endpackage

// File: rtl/synchronizer2.sv
// Two-flop synchronizer with a parameterised reset value, shared by the
// input and output conditioners.
module synchronizer2 #(
  parameter logic resetvalue = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic synchronizer0_r;
  logic synchronizer1_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      synchronizer0_r <= resetvalue;
      synchronizer1_r <= resetvalue;
    end else begin
      synchronizer0_r <= d;
      synchronizer1_r <= synchronizer0_r;
    end
  end

  assign q = synchronizer1_r;

endmodule

// File: rtl/output_conditioner.sv
// Drives a glitch-free, dwell-limited registered pin from a requested level.
// Define OUTPUTCONDITIONER_SYNC_EN to pass `desired` through a 2-flop synchronizer.
module output_conditioner
  import output_conditioner_pkg::*;
#(
  parameter int   counterwidth = DEFAULT_COUNTERWIDTH,
  parameter int   waittime     = DEFAULT_WAITTIME,
  parameter logic idlelevel    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic desired,
  output logic pin,
  output logic busy,
  output logic positiveedge,
  output logic negativeedge
);

  localparam logic [counterwidth-1:0] COUNT_LAST = counterwidth'(waittime - 1);
  localparam logic [counterwidth-1:0] COUNT_ONE  = counterwidth'(1);
  localparam logic [counterwidth-1:0] COUNT_ZERO = {counterwidth{1'b0}};

  logic                    desired_s;
  state_t                  state_r;
  logic [counterwidth-1:0] counter_r;
  logic                    pin_r;
  logic                    busy_r;
  logic                    positiveedge_r;
  logic                    negativeedge_r;

`ifdef OUTPUTCONDITIONER_SYNC_EN
  synchronizer2 #(
    .resetvalue (idlelevel)
  ) u_synchronizer2 (
    .clk   (clk),
    .reset (reset),
    .d     (desired),
    .q     (desired_s)
  );
`else
  assign desired_s = desired;
`endif

  // Dwell FSM: a level change is taken in IDLE or on the expiry edge of a dwell,
  // and each taken change restarts the dwell with counter at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= STATE_IDLE;
      counter_r      <= COUNT_ZERO;
      pin_r          <= idlelevel;
      busy_r         <= 1'b0;
      positiveedge_r <= 1'b0;
      negativeedge_r <= 1'b0;
    end else begin
      positiveedge_r <= 1'b0;
      negativeedge_r <= 1'b0;
      case (state_r)
        STATE_IDLE: begin
          if (desired_s != pin_r) begin
            pin_r          <= desired_s;
            positiveedge_r <= desired_s;
            negativeedge_r <= ~desired_s;
            counter_r      <= COUNT_ZERO;
            state_r        <= STATE_DWELL;
            busy_r         <= 1'b1;
          end else begin
            state_r <= STATE_IDLE;
            busy_r  <= 1'b0;
          end
        end
        STATE_DWELL: begin
          if (counter_r == COUNT_LAST) begin
            if (desired_s != pin_r) begin
              pin_r          <= desired_s;
              positiveedge_r <= desired_s;
              negativeedge_r <= ~desired_s;
              counter_r      <= COUNT_ZERO;
              state_r        <= STATE_DWELL;
              busy_r         <= 1'b1;
            end else begin
              state_r <= STATE_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            counter_r <= counter_r + COUNT_ONE;
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= STATE_IDLE;
          counter_r <= COUNT_ZERO;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign pin          = pin_r;
  assign busy         = busy_r;
  assign positiveedge = positiveedge_r;
  assign negativeedge = negativeedge_r;

endmodule

// File: tb/tb_output_conditioner.sv
// Scoreboard bench for output_conditioner: a time-since-last-transition model
// predicts each cycle's outputs; a monitor compares them after every edge.
module tb_output_conditioner;

  localparam int   CW   = 3;
  localparam int   WT   = 3;
  localparam logic IDLE = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic desired;
  logic pin;
  logic busy;
  logic positiveedge;
  logic negativeedge;

  always #5 clk = ~clk;

  output_conditioner #(
    .counterwidth (CW),
    .waittime     (WT),
    .idlelevel    (IDLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .desired      (desired),
    .pin          (pin),
    .busy         (busy),
    .positiveedge (positiveedge),
    .negativeedge (negativeedge)
  );

  typedef struct packed {
    logic pin;
    logic busy;
    logic pe;
    logic ne;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: the pin level plus the number of cycles it has been shown.
  logic m_pin = IDLE;
  int   m_age = WT;
  logic m_s0  = IDLE;
  logic m_s1  = IDLE;

  task automatic model_step(input logic r, input logic d);
    logic eff;
    exp_t e;
`ifdef OUTPUTCONDITIONER_SYNC_EN
    eff = m_s1;
    if (r) begin
      m_s0 = IDLE;
      m_s1 = IDLE;
    end else begin
      m_s1 = m_s0;
      m_s0 = d;
    end
`else
    eff = d;
`endif
    if (r) begin
      m_pin = IDLE;
      m_age = WT;
      e = '{pin: IDLE, busy: 1'b0, pe: 1'b0, ne: 1'b0};
    end else if (eff != m_pin && m_age >= WT - 1) begin
      m_pin = eff;
      m_age = 0;
      e = '{pin: eff, busy: 1'b1, pe: eff, ne: ~eff};
    end else begin
      m_age = (m_age >= WT) ? WT : m_age + 1;
      e = '{pin: m_pin, busy: (m_age < WT), pe: 1'b0, ne: 1'b0};
    end
    sb_q.push_back(e);
  endtask

  task automatic apply(input logic r, input logic d);
    @(negedge clk);
    reset   = r;
    desired = d;
    model_step(r, d);
  endtask

  // Monitor: compare the DUT outputs after every edge for which a prediction exists
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        vectors++;
        if ({pin, busy, positiveedge, negativeedge} !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got pin=%b busy=%b pos=%b neg=%b expected pin=%b busy=%b pos=%b neg=%b",
                   $time, pin, busy, positiveedge, negativeedge, e.pin, e.busy, e.pe, e.ne);
        end
      end
    end
  end

  initial begin
    logic d;
    int   hold;
    reset   = 1'b1;
    desired = 1'b1;
    // Reset held with desired high, then release
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b1);
    repeat (5) apply(1'b0, 1'b1);
    // Idle rise, then fall requested one cycle after pin rises
    apply(1'b0, 1'b0);
    repeat (5) apply(1'b0, 1'b0);
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);
    repeat (5) apply(1'b0, 1'b0);
    // Glitch inside a dwell
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);
    apply(1'b0, 1'b1);
    repeat (5) apply(1'b0, 1'b1);
    // Reset mid-dwell of a rise
    apply(1'b0, 1'b0);
    repeat (5) apply(1'b0, 1'b0);
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b1);
    apply(1'b1, 1'b1);
    repeat (4) apply(1'b0, 1'b0);
    // Random levels with varied hold lengths and occasional reset
    d = 1'b0;
    repeat (600) begin
      d    = ($urandom_range(0, 99) < 60) ? ~d : d;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 8) : $urandom_range(1, 2);
      for (int i = 0; i < hold; i++) begin
        apply(($urandom_range(0, 199) == 0), d);
      end
    end
    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
